// File: rtl/prog_loader.sv
// Program-memory loader: takes a framed byte stream (A5, count, words MSB-first,
// checksum), writes the words into program memory from address 0 and keeps the
// CPU held until a frame with a good checksum has landed.
module prog_loader #(
  parameter int IW    = 24,
  parameter int PSIZE = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             pm_we,
  output logic [PSIZE-1:0] pm_addr,
  output logic [IW-1:0]    pm_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);
  localparam int BPW = IW / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CAP = 2 ** PSIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t           state, state_nx;
  logic [PSIZE:0]   word_cnt;   // PSIZE+1 bits so a full memory's worth fits
  logic [PSIZE:0]   word_idx;
  logic [PSIZE:0]   word_idx_inc;
  logic [BW-1:0]    byte_idx;
  logic [7:0]       sum;
  logic [IW-1:0]    asm_q;
  logic [IW-1:0]    asm_nx;
  logic [31:0]      n_ext;
  logic             acc, hdr, last_byte, last_word, count_bad, sum_ok;

  assign rx_ready     = (state != S_ERR);
  assign acc          = rx_valid && rx_ready;
  assign hdr          = acc && (rx_data == 8'hA5) && (state == S_IDLE || state == S_DONE);
  assign n_ext        = {24'd0, rx_data};
  assign count_bad    = (rx_data == 8'd0) || (n_ext > 32'(CAP));
  assign last_byte    = (byte_idx == BW'(BPW - 1));
  assign word_idx_inc = word_idx + (PSIZE+1)'(1);
  assign last_word    = (word_idx_inc == word_cnt);
  assign sum_ok       = ((sum + rx_data) == 8'd0);
  assign asm_nx       = (asm_q << 8) | IW'(rx_data);

  // The CPU runs only while a verified image is resident; done mirrors that.
  assign cpu_hold = (state != S_DONE);
  assign done     = (state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; ERR lasts one cycle so the source sees a single stall
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (hdr) state_nx = S_COUNT;
      S_COUNT: if (acc) state_nx = count_bad ? S_ERR : S_DATA;
      S_DATA:  if (acc && last_byte && last_word) state_nx = S_CHECK;
      S_CHECK: if (acc) state_nx = sum_ok ? S_DONE : S_ERR;
      S_DONE:  if (hdr) state_nx = S_COUNT;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Word assembly, checksum accumulation, memory write port and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      sum      <= '0;
      asm_q    <= '0;
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
      error    <= 1'b0;
    end else begin
      pm_we <= 1'b0;
      if (state == S_COUNT && acc) begin
        word_cnt <= (PSIZE+1)'(rx_data);
        word_idx <= '0;
        byte_idx <= '0;
        sum      <= '0;
      end
      if (state == S_DATA && acc) begin
        asm_q <= asm_nx;
        sum   <= sum + rx_data;
        if (last_byte) begin
          pm_we    <= 1'b1;
          pm_addr  <= word_idx[PSIZE-1:0];
          pm_wdata <= asm_nx;
          word_idx <= word_idx_inc;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + BW'(1);
        end
      end
      if (hdr)
        error <= 1'b0;
      else if (state_nx == S_ERR && state != S_ERR)
        error <= 1'b1;
    end
  end

endmodule
